// File: rtl/qbert_pkg.sv
// Shared types and helpers for the Q*bert jump controller and its offset mapper.
package qbert_pkg;

  typedef enum logic [2:0] {IDLE, JUMP, FALL, DONE, OVER} state_t;

  typedef enum logic [1:0] {UL, UR, DL, DR} dir_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] n;
  } pos_t;

  // First cube id of each rank, rank 0 in the low field.
  localparam logic [8:0] RANK_BASE = {3'd5, 3'd3, 3'd0};

  function automatic logic [2:0] cube_id(pos_t p);
    logic [2:0] base;
    case (p.r)
      2'd1:    base = RANK_BASE[5:3];
      2'd2:    base = RANK_BASE[8:6];
      default: base = RANK_BASE[2:0];
    endcase
    return base + {1'b0, p.n};
  endfunction

endpackage

// File: rtl/qbert_pos_to_offset.sv
// Combinational cube position to sprite x/y offset; reusable for enemy sprites.
module qbert_pos_to_offset
  import qbert_pkg::*;
#(
  parameter logic [10:0] XLENGTH    = 11'd55,
  parameter logic [10:0] XDIAG_DEMI = 11'd30,
  parameter logic [9:0]  YDIAG_DEMI = 10'd50,
  parameter logic [10:0] X0         = 11'd600,
  parameter logic [9:0]  Y0         = 10'd90
) (
  input  pos_t        pos,
  output logic [10:0] x_offset,
  output logic [9:0]  y_offset
);

  always_comb begin
    x_offset = X0 - ({9'd0, pos.r} * (XLENGTH + XDIAG_DEMI)) - {10'd0, pos.r != 2'd0};
    y_offset = Y0 + ({8'd0, pos.r} * YDIAG_DEMI) + ({8'd0, pos.n} * (YDIAG_DEMI << 1))
             + {9'd0, pos.n != 2'd0};
  end

endmodule

// File: rtl/qbert_jump_ctrl.sv
// Q*bert game-state stage: move FSM, frame-paced jump/fall, lives and visited mask.
// Define QBERT_TOGGLE_EN to make a valid landing toggle (not set) the cube's visited bit.
module qbert_jump_ctrl
  import qbert_pkg::*;
#(
  parameter logic [10:0] XLENGTH     = 11'd55,
  parameter logic [10:0] XDIAG_DEMI  = 11'd30,
  parameter logic [9:0]  YDIAG_DEMI  = 10'd50,
  parameter logic [10:0] X0          = 11'd600,
  parameter logic [9:0]  Y0          = 10'd90,
  parameter logic [3:0]  JUMP_FRAMES = 4'd6,
  parameter logic [4:0]  FALL_FRAMES = 5'd20,
  parameter logic [1:0]  LIVES       = 2'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        restart,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic [10:0] x_offset,
  output logic [9:0]  y_offset,
  output logic [5:0]  visited,
  output logic        top_cube,
  output logic [1:0]  lives,
  output logic        falling,
  output logic        game_over
);

  localparam pos_t        SpawnPos  = '{r: 2'd2, n: 2'd0};
  localparam logic [5:0]  SpawnMask = 6'b100000;
  localparam logic [10:0] XSpawn    = X0 - 11'd2 * (XLENGTH + XDIAG_DEMI) - 11'd1;
  localparam logic [9:0]  YSpawn    = Y0 + 10'd2 * YDIAG_DEMI;
  localparam logic [4:0]  JumpLast  = {1'b0, JUMP_FRAMES} - 5'd1;
  localparam logic [4:0]  FallLast  = FALL_FRAMES - 5'd1;

  state_t      state_q, state_d;
  pos_t        pos_q, pos_d, dest_q, dest_d;
  logic        dest_ok_q, dest_ok_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  lives_q, lives_d;
  logic [5:0]  visited_q, visited_d;
  logic [10:0] x_q, x_pos;
  logic [9:0]  y_q, y_pos;

  logic signed [2:0] dst_r, dst_n;
  logic              dst_ok;
  logic [5:0]        land_mask;

  // Signed destination so that stepping off either edge is caught.
  always_comb begin
    dst_r = $signed({1'b0, pos_q.r});
    dst_n = $signed({1'b0, pos_q.n});
    case (dir_t'(move_dir))
      UL: begin
        dst_r = dst_r + 3'sd1;
        dst_n = dst_n - 3'sd1;
      end
      UR:      dst_r = dst_r + 3'sd1;
      DL:      dst_r = dst_r - 3'sd1;
      default: begin
        dst_r = dst_r - 3'sd1;
        dst_n = dst_n + 3'sd1;
      end
    endcase
    dst_ok = (dst_r >= 3'sd0) && (dst_r <= 3'sd2) && (dst_n >= 3'sd0) &&
             (dst_n <= 3'sd2 - dst_r);
  end

  always_comb begin
`ifdef QBERT_TOGGLE_EN
    land_mask = visited_q ^ (6'd1 << cube_id(dest_q));
`else
    land_mask = visited_q | (6'd1 << cube_id(dest_q));
`endif
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dest_d    = dest_q;
    dest_ok_d = dest_ok_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    visited_d = visited_q;
    if (restart) begin
      state_d   = IDLE;
      pos_d     = SpawnPos;
      dest_d    = SpawnPos;
      dest_ok_d = 1'b0;
      cnt_d     = '0;
      lives_d   = LIVES;
      visited_d = SpawnMask;
    end else begin
      case (state_q)
        IDLE: begin
          if (move_valid) begin
            dest_d    = '{r: dst_r[1:0], n: dst_n[1:0]};
            dest_ok_d = dst_ok;
            cnt_d     = '0;
            state_d   = JUMP;
          end
        end
        JUMP: begin
          if (frame_tick) begin
            if (cnt_q == JumpLast) begin
              cnt_d = '0;
              if (dest_ok_q) begin
                pos_d     = dest_q;
                visited_d = land_mask;
                state_d   = (land_mask == 6'h3F) ? DONE : IDLE;
              end else begin
                state_d = FALL;
              end
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        FALL: begin
          if (frame_tick) begin
            if (cnt_q == FallLast) begin
              cnt_d   = '0;
              lives_d = lives_q - 2'd1;
              if (lives_q == 2'd1) begin
                state_d = OVER;
              end else begin
                pos_d     = SpawnPos;
                visited_d = visited_q | SpawnMask;
                state_d   = IDLE;
              end
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pos_q     <= SpawnPos;
      dest_q    <= SpawnPos;
      dest_ok_q <= 1'b0;
      cnt_q     <= '0;
      lives_q   <= LIVES;
      visited_q <= SpawnMask;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dest_q    <= dest_d;
      dest_ok_q <= dest_ok_d;
      cnt_q     <= cnt_d;
      lives_q   <= lives_d;
      visited_q <= visited_d;
    end
  end

  qbert_pos_to_offset #(
    .XLENGTH   (XLENGTH),
    .XDIAG_DEMI(XDIAG_DEMI),
    .YDIAG_DEMI(YDIAG_DEMI),
    .X0        (X0),
    .Y0        (Y0)
  ) u_pos_to_offset (
    .pos     (pos_q),
    .x_offset(x_pos),
    .y_offset(y_pos)
  );

  // Offsets trail the position register by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= XSpawn;
      y_q <= YSpawn;
    end else if (restart) begin
      x_q <= XSpawn;
      y_q <= YSpawn;
    end else begin
      x_q <= x_pos;
      y_q <= y_pos;
    end
  end

  assign move_ready = (state_q == IDLE);
  assign x_offset   = x_q;
  assign y_offset   = y_q;
  assign visited    = visited_q;
  assign top_cube   = (state_q == DONE);
  assign lives      = lives_q;
  assign falling    = (state_q == FALL);
  assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Self-checking bench for qbert_jump_ctrl: directed scenarios plus random play vs a game model.
module tb_qbert_jump_ctrl;

  localparam int DirUl = 0;
  localparam int DirUr = 1;
  localparam int DirDl = 2;
  localparam int DirDr = 3;

  localparam int MIdle = 0;
  localparam int MJump = 1;
  localparam int MFall = 2;
  localparam int MDone = 3;
  localparam int MOver = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        restart = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready;
  logic [10:0] x_offset;
  logic [9:0]  y_offset;
  logic [5:0]  visited;
  logic        top_cube;
  logic [1:0]  lives;
  logic        falling;
  logic        game_over;

  int n_checks = 0;
  int n_fails  = 0;

  // Game model state
  int m_mode, m_cnt, m_r, m_n, m_dr, m_dn, m_lives, m_vis, m_x, m_y;

  qbert_jump_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .restart   (restart),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .move_ready(move_ready),
    .x_offset  (x_offset),
    .y_offset  (y_offset),
    .visited   (visited),
    .top_cube  (top_cube),
    .lives     (lives),
    .falling   (falling),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cube_of(input int r, input int n);
    if (r == 0) return n;
    if (r == 1) return 3 + n;
    return 5;
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_cnt = 0; m_r = 2; m_n = 0; m_dr = 2; m_dn = 0;
    m_lives = 3; m_vis = 32; m_x = 429; m_y = 190;
  endtask

  task automatic model_step(input int mv, input int d, input int tk, input int rs);
    // Offsets show where Q*bert stood before this edge.
    m_x = 600 - m_r * 85 - ((m_r != 0) ? 1 : 0);
    m_y = 90 + m_r * 50 + m_n * 100 + ((m_n != 0) ? 1 : 0);
    if (rs != 0) begin
      model_reset();
    end else if (m_mode == MIdle) begin
      if (mv != 0) begin
        case (d)
          DirUl:   begin m_dr = m_r + 1; m_dn = m_n - 1; end
          DirUr:   begin m_dr = m_r + 1; m_dn = m_n;     end
          DirDl:   begin m_dr = m_r - 1; m_dn = m_n;     end
          default: begin m_dr = m_r - 1; m_dn = m_n + 1; end
        endcase
        m_mode = MJump;
        m_cnt  = 0;
      end
    end else if (m_mode == MJump && tk != 0) begin
      m_cnt++;
      if (m_cnt == 6) begin
        m_cnt = 0;
        if (m_dr >= 0 && m_dr <= 2 && m_dn >= 0 && m_dn <= 2 - m_dr) begin
          m_r = m_dr;
          m_n = m_dn;
`ifdef QBERT_TOGGLE_EN
          m_vis = m_vis ^ (1 << cube_of(m_r, m_n));
`else
          m_vis = m_vis | (1 << cube_of(m_r, m_n));
`endif
          m_mode = (m_vis == 63) ? MDone : MIdle;
        end else begin
          m_mode = MFall;
        end
      end
    end else if (m_mode == MFall && tk != 0) begin
      m_cnt++;
      if (m_cnt == 20) begin
        m_cnt = 0;
        m_lives--;
        if (m_lives == 0) begin
          m_mode = MOver;
        end else begin
          m_r = 2; m_n = 0; m_vis = m_vis | 32; m_mode = MIdle;
        end
      end
    end
  endtask

  task automatic check_all();
    check("move_ready", 32'(move_ready), 32'(m_mode == MIdle));
    check("x_offset", 32'(x_offset), m_x);
    check("y_offset", 32'(y_offset), m_y);
    check("visited", 32'(visited), m_vis);
    check("top_cube", 32'(top_cube), 32'(m_mode == MDone));
    check("lives", 32'(lives), m_lives);
    check("falling", 32'(falling), 32'(m_mode == MFall));
    check("game_over", 32'(game_over), 32'(m_mode == MOver));
  endtask

  task automatic step(input int mv, input int d, input int tk, input int rs);
    move_valid = mv[0];
    move_dir   = d[1:0];
    frame_tick = tk[0];
    restart    = rs[0];
    @(posedge clk);
    model_step(mv, d, tk, rs);
    #1;
    check_all();
  endtask

  task automatic ticks(input int count);
    for (int i = 0; i < count; i++) step(0, 0, 1, 0);
  endtask

  task automatic do_move(input int d);
    step(1, d, 0, 0);
    step(0, 0, 0, 0);
    ticks(6);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_x", 32'(x_offset), 429);
    check("rst_y", 32'(y_offset), 190);
    check("rst_visited", 32'(visited), 32);
    check("rst_lives", 32'(lives), 3);
    check("rst_ready", 32'(move_ready), 1);
    check_all();

    // Single legal DL landing
    do_move(DirDl);
    step(0, 0, 0, 0);
    check("dl_x", 32'(x_offset), 514);
    check("dl_y", 32'(y_offset), 140);
    check("dl_visited", 32'(visited), 32'h28);
    check("dl_ready", 32'(move_ready), 1);

    // Three falls off the left edge
    step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      do_move(DirUl);
      check("fall_flag", 32'(falling), 1);
      ticks(20);
      if (k == 0) check("fall_lives", 32'(lives), 2);
    end
    check("over_flag", 32'(game_over), 1);
    check("over_ready", 32'(move_ready), 0);
    do_move(DirDl);

    // Tour of all six cubes, with a request dropped mid-jump
    step(0, 0, 0, 1);
    step(1, DirDl, 0, 0);
    ticks(2);
    step(1, DirDr, 1, 0);
    ticks(3);
    do_move(DirDl);
    do_move(DirUr);
    do_move(DirDr);
    do_move(DirUr);
    do_move(DirDr);
    step(0, 0, 0, 0);
    do_move(DirUr);

    // restart wins over the landing tick
    step(0, 0, 0, 1);
    step(1, DirDl, 0, 0);
    ticks(5);
    step(0, 0, 1, 1);
    check("rst_tick_visited", 32'(visited), 32);
    step(0, 0, 0, 0);

    // Async reset mid-jump abandons the animation
    step(1, DirDl, 0, 0);
    ticks(3);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_ready", 32'(move_ready), 1);
    check("async_x", 32'(x_offset), 429);
    @(negedge clk);
    reset = 1'b1;
    ticks(6);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 2) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 299) == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
